ray_gen: RTL

Primary-ray generator: walks an H_RES × V_RES pixel grid in raster order and emits one camera ray (origin, direction) per pixel over a valid/ready stream. It sits upstream of the ray–plane intersection stage and produces its origin and direction operands. Directions are formed incrementally with vector adds, so no multipliers or dividers are used. All vectors are three signed Q16.16 lanes packed into 96 bits: x in [31:0], y in [63:32], z in [95:64].

---
 rtl/ray_gen_pkg.sv | 29 ++
 rtl/ray_gen_vec3_add.sv | 18 +
 rtl/ray_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ray_gen_pkg.sv
// Shared types and constants for the primary-ray generator: Q16.16 lanes,
// the packed three-lane vector and the frame-walk state encoding.
package ray_gen_pkg;

   localparam logic [31:0] Q_ONE     = 32'h0001_0000;
   localparam int unsigned FRAC_BITS = 16;

   localparam int unsigned LANE_W    = 32;
   localparam int unsigned NUM_LANES = 3;
   localparam int unsigned VEC_W     = LANE_W * NUM_LANES;
   localparam int unsigned X_LSB     = 0;
   localparam int unsigned Y_LSB     = 32;
   localparam int unsigned Z_LSB     = 64;

   typedef logic [VEC_W-1:0] vec3_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Two's-complement lane add; carries out of bit 31 are discarded (wraps).
   function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/ray_gen_vec3_add.sv
// Three-lane wrapping Q16.16 vector adder; lanes are independent, no carry
// crosses a lane boundary.
module vec3_add
   import ray_gen_pkg::*;
(
   input  vec3_t a,
   input  vec3_t b,
   output vec3_t sum
);

   always_comb begin
      sum = '0;
      sum[X_LSB +: LANE_W] = lane_add(a[X_LSB +: LANE_W], b[X_LSB +: LANE_W]);
      sum[Y_LSB +: LANE_W] = lane_add(a[Y_LSB +: LANE_W], b[Y_LSB +: LANE_W]);
      sum[Z_LSB +: LANE_W] = lane_add(a[Z_LSB +: LANE_W], b[Z_LSB +: LANE_W]);
   end

endmodule

// File: rtl/ray_gen.sv
// Primary-ray generator: walks an H_RES x V_RES grid in raster order and
// streams one (origin, direction) ray per pixel over valid/ready.
module ray_gen
   import ray_gen_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int XW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  vec3_t         cam_origin,
   input  vec3_t         dir_base,
   input  vec3_t         dir_du,
   input  vec3_t         dir_dv,
   output logic          busy,
   output logic          done,
   output logic          ray_valid,
   input  logic          ray_ready,
   output vec3_t         ray_origin,
   output vec3_t         ray_dir,
   output logic [XW-1:0] ray_col,
   output logic [XW-1:0] ray_row,
   output logic          ray_last
);

   localparam logic [XW-1:0] COL_MAX = XW'(H_RES - 1);
   localparam logic [XW-1:0] ROW_MAX = XW'(V_RES - 1);

   state_t        state_q, state_d;
   vec3_t         origin_q, origin_d;
   vec3_t         dir_q, dir_d;
   vec3_t         row_start_q, row_start_d;
   vec3_t         du_q, du_d;
   vec3_t         dv_q, dv_d;
   logic [XW-1:0] col_q, col_d;
   logic [XW-1:0] row_q, row_d;

   vec3_t         dir_step;
   vec3_t         row_next;

   vec3_add u_add_col (.a(dir_q),       .b(du_q), .sum(dir_step));
   vec3_add u_add_row (.a(row_start_q), .b(dv_q), .sum(row_next));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         origin_q    <= '0;
         dir_q       <= '0;
         row_start_q <= '0;
         du_q        <= '0;
         dv_q        <= '0;
         col_q       <= '0;
         row_q       <= '0;
      end else begin
         state_q     <= state_d;
         origin_q    <= origin_d;
         dir_q       <= dir_d;
         row_start_q <= row_start_d;
         du_q        <= du_d;
         dv_q        <= dv_d;
         col_q       <= col_d;
         row_q       <= row_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      origin_d    = origin_q;
      dir_d       = dir_q;
      row_start_d = row_start_q;
      du_d        = du_q;
      dv_d        = dv_q;
      col_d       = col_q;
      row_d       = row_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               origin_d    = cam_origin;
               du_d        = dir_du;
               dv_d        = dir_dv;
               dir_d       = dir_base;
               row_start_d = dir_base;
               col_d       = '0;
               row_d       = '0;
               state_d     = ST_EMIT;
            end
         end
         ST_EMIT: begin
            // Next pixel is registered on the handshake edge itself.
            if (ray_ready) begin
               if (col_q != COL_MAX) begin
                  col_d = col_q + 1'b1;
                  dir_d = dir_step;
               end else if (row_q != ROW_MAX) begin
                  col_d       = '0;
                  row_d       = row_q + 1'b1;
                  row_start_d = row_next;
                  dir_d       = row_next;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Status decoded from the state register so reset clears it asynchronously.
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FIN);
   assign ray_valid  = (state_q == ST_EMIT);
   assign ray_last   = ray_valid && (col_q == COL_MAX) && (row_q == ROW_MAX);
   assign ray_origin = origin_q;
   assign ray_dir    = dir_q;
   assign ray_col    = col_q;
   assign ray_row    = row_q;

endmodule
